// File: rtl/data_ram_arbiter_pkg.sv
// Shared types and constants for the data_ram arbiter and its picker.
package data_ram_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_e;

  // Master identifiers as stored in last_gnt
  localparam logic ARB_M0 = 1'b0;
  localparam logic ARB_M1 = 1'b1;

  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic WRITE_ENABLE = 1'b1;

  // Saturating increment used by the M1 starvation counter
  function automatic logic [3:0] sat_inc4(input logic [3:0] val, input logic [3:0] max_val);
    return (val >= max_val) ? max_val : val + 4'd1;
  endfunction

endpackage

// File: rtl/data_ram_arbiter_rr2.sv
// Two-way grant picker: single requester wins outright; on contention either
// round-robin against the last winner or fixed M0 priority with a force-M1 override.
module data_ram_arbiter_rr2
  import data_ram_arbiter_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  input  logic       i_fixed,
  input  logic       i_force1,
  output logic [1:0] o_gnt
);

  // One-hot grant selection
  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01: o_gnt = 2'b01;
      2'b10: o_gnt = 2'b10;
      2'b11: begin
        if (i_fixed) begin
          o_gnt = i_force1 ? 2'b10 : 2'b01;
        end else begin
          o_gnt = (i_last == ARB_M1) ? 2'b01 : 2'b10;
        end
      end
      default: o_gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/data_ram_arbiter.sv
// Arbitrates the single-port data_ram between the CPU MEM stage (M0) and a
// DMA/debug loader (M1). One access per cycle, optional bus lock per master.
module data_ram_arbiter
  import data_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0,
  parameter int MAX_WAIT   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_req,
  input  logic                m0_we,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W/8-1:0] m0_sel,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic                m0_lock,
  output logic                m0_gnt,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W/8-1:0] m1_sel,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic                m1_lock,
  output logic                m1_gnt,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                ram_ce,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W/8-1:0] ram_sel,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);
  localparam logic       FIXED_C    = (FIXED_PRIO != 0);

  arb_state_e        r_state;
  logic              r_last_gnt;
  logic [3:0]        r_wait_cnt;
  logic [1:0]        r_rvalid;
  logic [DATA_W-1:0] r_rdata [2];

  logic [1:0] w_pick_gnt;
  logic [1:0] w_gnt;
  logic [1:0] w_rd_req;

  data_ram_arbiter_rr2 u_pick (
    .i_req    ({m1_req, m0_req}),
    .i_last   (r_last_gnt),
    .i_fixed  (FIXED_C),
    .i_force1 (r_wait_cnt == MAX_WAIT_C),
    .o_gnt    (w_pick_gnt)
  );

  // Final grant: picker when idle, owner only when locked, nothing in reset
  always_comb begin
    w_gnt = 2'b00;
    if (rst) begin
      case (r_state)
        ARB_IDLE: w_gnt = w_pick_gnt;
        ARB_OWN0: w_gnt = {1'b0, m0_req};
        ARB_OWN1: w_gnt = {m1_req, 1'b0};
        default:  w_gnt = 2'b00;
      endcase
    end
  end

  assign m0_gnt   = w_gnt[0];
  assign m1_gnt   = w_gnt[1];
  assign w_rd_req = {w_gnt[1] & ~m1_we, w_gnt[0] & ~m0_we};

  // Steer the granted master onto the RAM port; all zero when nobody is granted
  always_comb begin
    ram_ce    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_sel   = '0;
    ram_wdata = '0;
    if (w_gnt[0]) begin
      ram_ce    = CHIP_ENABLE;
      ram_we    = m0_we ? WRITE_ENABLE : 1'b0;
      ram_addr  = m0_addr;
      ram_sel   = m0_sel;
      ram_wdata = m0_wdata;
    end else if (w_gnt[1]) begin
      ram_ce    = CHIP_ENABLE;
      ram_we    = m1_we ? WRITE_ENABLE : 1'b0;
      ram_addr  = m1_addr;
      ram_sel   = m1_sel;
      ram_wdata = m1_wdata;
    end
  end

  // Ownership FSM, last-winner memory and M1 starvation counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ARB_IDLE;
      r_last_gnt <= ARB_M1;
      r_wait_cnt <= 4'd0;
    end else begin
      if (w_gnt[0]) begin
        r_last_gnt <= ARB_M0;
      end else if (w_gnt[1]) begin
        r_last_gnt <= ARB_M1;
      end

      if (m1_req && !w_gnt[1]) begin
        r_wait_cnt <= sat_inc4(r_wait_cnt, MAX_WAIT_C);
      end else begin
        r_wait_cnt <= 4'd0;
      end

      case (r_state)
        ARB_IDLE: begin
          if (w_gnt[0] && m0_lock) begin
            r_state <= ARB_OWN0;
          end else if (w_gnt[1] && m1_lock) begin
            r_state <= ARB_OWN1;
          end
        end
        ARB_OWN0: if (!(m0_req && m0_lock)) r_state <= ARB_IDLE;
        ARB_OWN1: if (!(m1_req && m1_lock)) r_state <= ARB_IDLE;
        default:  r_state <= ARB_IDLE;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      // Capture RAM read data for master gi at the edge closing its read grant
      always_ff @(posedge clk) begin
        if (!rst) begin
          r_rvalid[gi] <= 1'b0;
          r_rdata[gi]  <= '0;
        end else begin
          r_rvalid[gi] <= w_rd_req[gi];
          if (w_rd_req[gi]) begin
            r_rdata[gi] <= ram_rdata;
          end
        end
      end
    end
  endgenerate

  assign m0_rvalid = r_rvalid[0];
  assign m1_rvalid = r_rvalid[1];
  assign m0_rdata  = r_rdata[0];
  assign m1_rdata  = r_rdata[1];

endmodule
